// File: rtl/cpu_pkg.sv
// Shared widths, reset address and PC-unit state encoding for the 6502 datapath.
package cpu_pkg;
  localparam int BYTE_W = 8;
  localparam int ADDR_W = 16;
  localparam logic [15:0] RESET_ADDR = 16'h0000;

  typedef enum logic {IDLE, FIX} state_t;
endpackage

// File: rtl/pc_unit_edge_rise.sv
// Registered rising-edge detector: a level held for many cycles yields one rise pulse.
module edge_rise #(
  parameter int N = 6
) (
  input  logic         sys_clock,
  input  logic         reset,
  input  logic [N-1:0] level,
  output logic [N-1:0] rise
);
  logic [N-1:0] prev;

  always_ff @(posedge sys_clock) begin
    if (reset) prev <= '0;
    else       prev <= level;
  end

  assign rise = level & ~prev;
endmodule

// File: rtl/pc_unit.sv
// Program counter with split byte halves, relative branches with page-cross fix-up
// and vector loads; all PC updates commit only on phase_2_rising.
module pc_unit #(
  parameter int BYTE_W = cpu_pkg::BYTE_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = cpu_pkg::RESET_ADDR
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic              phase_2_rising,
  input  logic              pcl_pcl,
  input  logic              adl_pcl,
  input  logic              pch_pch,
  input  logic              adh_pch,
  input  logic              increment_pc,
  input  logic              branch_take,
  input  logic [BYTE_W-1:0] branch_offset,
  input  logic              vec_load,
  input  logic [ADDR_W-1:0] vec_addr,
  input  logic [BYTE_W-1:0] address_l_in,
  input  logic [BYTE_W-1:0] address_h_in,
  input  logic              pcl_adl,
  input  logic              pch_adh,
  input  logic              pcl_db,
  input  logic              pch_db,
  output logic [BYTE_W-1:0] adl_out,
  output logic [BYTE_W-1:0] adh_out,
  output logic [BYTE_W-1:0] db_out,
  output logic              adl_oe,
  output logic              adh_oe,
  output logic              db_oe,
  output logic [ADDR_W-1:0] pc,
  output logic              branch_busy,
  output logic              page_cross
);
  import cpu_pkg::*;

  localparam int R_PCL = 0, R_ADL = 1, R_PCH = 2, R_ADH = 3, R_BR = 4, R_VEC = 5;

  logic [5:0]        rise;
  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_q, pc_nx, sel_q, sel_nx, sel_base;
  logic              vec_pend, vec_pend_nx, br_pend, br_pend_nx;
  logic [BYTE_W-1:0] offset_q, offset_nx;
  logic              dir_neg, dir_neg_nx, cross_nx;
  logic [BYTE_W:0]   lo_sum;

  edge_rise #(.N(6)) u_edge (
    .sys_clock (sys_clock),
    .reset     (reset),
    .level     ({vec_load, branch_take, adh_pch, pch_pch, adl_pcl, pcl_pcl}),
    .rise      (rise)
  );

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state      <= IDLE;
      pc_q       <= RESET_ADDR;
      sel_q      <= RESET_ADDR;
      vec_pend   <= 1'b0;
      br_pend    <= 1'b0;
      offset_q   <= '0;
      dir_neg    <= 1'b0;
      page_cross <= 1'b0;
    end else begin
      state      <= state_nx;
      pc_q       <= pc_nx;
      sel_q      <= sel_nx;
      vec_pend   <= vec_pend_nx;
      br_pend    <= br_pend_nx;
      offset_q   <= offset_nx;
      dir_neg    <= dir_neg_nx;
      page_cross <= cross_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc_q;
    dir_neg_nx  = dir_neg;
    cross_nx    = 1'b0;
    vec_pend_nx = vec_pend;
    br_pend_nx  = br_pend;
    offset_nx   = offset_q;
    lo_sum      = {1'b0, pc_q[BYTE_W-1:0]} + {1'b0, offset_q};

    if (phase_2_rising) begin
      case (state)
        IDLE: begin
          if (vec_pend) begin
            pc_nx       = vec_addr;
            vec_pend_nx = 1'b0;
          end else if (br_pend) begin
            pc_nx      = {pc_q[ADDR_W-1:BYTE_W], lo_sum[BYTE_W-1:0]};
            br_pend_nx = 1'b0;
            // Carry out with a positive offset, or no borrow-back with a negative one, leaves the page.
            if (offset_q[BYTE_W-1] != lo_sum[BYTE_W]) begin
              state_nx   = FIX;
              dir_neg_nx = offset_q[BYTE_W-1];
            end
          end else begin
            pc_nx = sel_q + ADDR_W'(increment_pc);
          end
        end
        FIX: begin
          pc_nx[ADDR_W-1:BYTE_W] = pc_q[ADDR_W-1:BYTE_W]
                                   + (dir_neg ? {BYTE_W{1'b1}} : BYTE_W'(1));
          state_nx = IDLE;
          cross_nx = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end

    // Rises landing on a commit cycle still register so they are not lost.
    if (rise[R_VEC]) vec_pend_nx = 1'b1;
    if (rise[R_BR]) begin
      br_pend_nx = 1'b1;
      offset_nx  = branch_offset;
    end

    sel_base = phase_2_rising ? pc_nx : sel_q;
    sel_nx   = sel_base;
    if (rise[R_PCH])      sel_nx[ADDR_W-1:BYTE_W] = pc_q[ADDR_W-1:BYTE_W];
    else if (rise[R_ADH]) sel_nx[ADDR_W-1:BYTE_W] = address_h_in;
    if (rise[R_PCL])      sel_nx[BYTE_W-1:0] = pc_q[BYTE_W-1:0];
    else if (rise[R_ADL]) sel_nx[BYTE_W-1:0] = address_l_in;
  end

  assign pc          = pc_q;
  assign branch_busy = (state == FIX);
  assign adl_out     = pc_q[BYTE_W-1:0];
  assign adh_out     = pc_q[ADDR_W-1:BYTE_W];
  assign adl_oe      = pcl_adl;
  assign adh_oe      = pch_adh;
  assign db_out      = pch_db ? pc_q[ADDR_W-1:BYTE_W] : pc_q[BYTE_W-1:0];
  assign db_oe       = pcl_db | pch_db;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: increments, bus loads/drives, branches, wrap, vectors, reset abort.
module tb_pc_unit;
  logic        sys_clock = 1'b0;
  logic        reset, phase_2_rising;
  logic        pcl_pcl, adl_pcl, pch_pch, adh_pch, increment_pc;
  logic        branch_take, vec_load;
  logic [7:0]  branch_offset, address_l_in, address_h_in;
  logic [15:0] vec_addr;
  logic        pcl_adl, pch_adh, pcl_db, pch_db;
  logic [7:0]  adl_out, adh_out, db_out;
  logic        adl_oe, adh_oe, db_oe;
  logic [15:0] pc;
  logic        branch_busy, page_cross;

  int checks = 0;
  int errors = 0;

  pc_unit dut (
    .sys_clock(sys_clock), .reset(reset), .phase_2_rising(phase_2_rising),
    .pcl_pcl(pcl_pcl), .adl_pcl(adl_pcl), .pch_pch(pch_pch), .adh_pch(adh_pch),
    .increment_pc(increment_pc), .branch_take(branch_take), .branch_offset(branch_offset),
    .vec_load(vec_load), .vec_addr(vec_addr),
    .address_l_in(address_l_in), .address_h_in(address_h_in),
    .pcl_adl(pcl_adl), .pch_adh(pch_adh), .pcl_db(pcl_db), .pch_db(pch_db),
    .adl_out(adl_out), .adh_out(adh_out), .db_out(db_out),
    .adl_oe(adl_oe), .adh_oe(adh_oe), .db_oe(db_oe),
    .pc(pc), .branch_busy(branch_busy), .page_cross(page_cross)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic commit(input logic inc);
    increment_pc   = inc;
    phase_2_rising = 1'b1;
    step();
    phase_2_rising = 1'b0;
    increment_pc   = 1'b0;
  endtask

  task automatic load_sel(input logic [7:0] lo, input logic [7:0] hi);
    address_l_in = lo;
    address_h_in = hi;
    adl_pcl = 1'b1;
    adh_pch = 1'b1;
    step();
    adl_pcl = 1'b0;
    adh_pch = 1'b0;
    step();
  endtask

  task automatic set_pc(input logic [15:0] v);
    load_sel(v[7:0], v[15:8]);
    commit(1'b0);
  endtask

  task automatic branch(input logic [7:0] off);
    branch_offset = off;
    branch_take   = 1'b1;
    step();
    branch_take   = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; phase_2_rising = 1'b0;
    pcl_pcl = 0; adl_pcl = 0; pch_pch = 0; adh_pch = 0; increment_pc = 0;
    branch_take = 0; vec_load = 0; branch_offset = '0; vec_addr = '0;
    address_l_in = '0; address_h_in = '0;
    pcl_adl = 0; pch_adh = 0; pcl_db = 0; pch_db = 0;
    step();
    step();
    reset = 1'b0;
    check("reset_pc", pc, 16'h0000);
    check("reset_busy", 16'(branch_busy), 16'h0);
    check("reset_cross", 16'(page_cross), 16'h0);
    check("reset_oe", 16'({adl_oe, adh_oe, db_oe}), 16'h0);

    // Three increments with hold strobes pulsed beforehand.
    for (int i = 1; i <= 3; i++) begin
      pcl_pcl = 1'b1; pch_pch = 1'b1;
      step();
      pcl_pcl = 1'b0; pch_pch = 1'b0;
      step();
      commit(1'b1);
      check("inc_pc", pc, 16'(i));
    end

    // Load from address buses and drive the buses.
    set_pc(16'h1234);
    check("load_pc", pc, 16'h1234);
    pcl_adl = 1'b1; pch_db = 1'b1; pcl_db = 1'b1;
    #1;
    check("adl_out", 16'(adl_out), 16'h0034);
    check("adl_oe", 16'(adl_oe), 16'h1);
    check("db_out_prio", 16'(db_out), 16'h0012);
    check("db_oe", 16'(db_oe), 16'h1);
    pch_db = 1'b0;
    #1;
    check("db_out_lo", 16'(db_out), 16'h0034);
    pcl_adl = 1'b0; pcl_db = 1'b0;

    // Forward branch crossing a page.
    set_pc(16'h10F0);
    branch(8'h20);
    commit(1'b1);
    check("brf_c1_pc", pc, 16'h1010);
    check("brf_c1_busy", 16'(branch_busy), 16'h1);
    check("brf_c1_cross", 16'(page_cross), 16'h0);
    commit(1'b0);
    check("brf_c2_pc", pc, 16'h1110);
    check("brf_c2_cross", 16'(page_cross), 16'h1);
    check("brf_c2_busy", 16'(branch_busy), 16'h0);
    step();
    check("brf_cross_pulse_end", 16'(page_cross), 16'h0);

    // Backward branch crossing a page.
    set_pc(16'h1005);
    branch(8'hF0);
    commit(1'b0);
    check("brb_c1_pc", pc, 16'h10F5);
    check("brb_c1_busy", 16'(branch_busy), 16'h1);
    commit(1'b0);
    check("brb_c2_pc", pc, 16'h0FF5);
    check("brb_c2_cross", 16'(page_cross), 16'h1);

    // Branch within the page.
    set_pc(16'h1005);
    branch(8'h02);
    commit(1'b1);
    check("brn_pc", pc, 16'h1007);
    check("brn_busy", 16'(branch_busy), 16'h0);
    check("brn_cross", 16'(page_cross), 16'h0);

    // Wrap and vector load.
    set_pc(16'hFFFF);
    check("wrap_pre", pc, 16'hFFFF);
    commit(1'b1);
    check("wrap_pc", pc, 16'h0000);
    vec_addr = 16'hFFFC;
    vec_load = 1'b1;
    step();
    vec_load = 1'b0;
    step();
    commit(1'b1);
    check("vec_pc", pc, 16'hFFFC);

    // Reset while a fix-up is pending, even on a commit cycle.
    set_pc(16'h10F0);
    branch(8'h20);
    commit(1'b0);
    check("rst_fix_busy_pre", 16'(branch_busy), 16'h1);
    reset = 1'b1; phase_2_rising = 1'b1;
    step();
    reset = 1'b0; phase_2_rising = 1'b0;
    check("rst_fix_pc", pc, 16'h0000);
    check("rst_fix_busy", 16'(branch_busy), 16'h0);
    check("rst_fix_cross", 16'(page_cross), 16'h0);
    step();
    check("rst_fix_cross_after", 16'(page_cross), 16'h0);

    // A level held for five cycles loads sel only on its first cycle.
    address_l_in = 8'h55;
    adl_pcl = 1'b1;
    step();
    address_l_in = 8'h66;
    repeat (4) step();
    adl_pcl = 1'b0;
    step();
    commit(1'b0);
    check("held_strobe_pc", pc, 16'h0055);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the 6502 core datapath, generalised from a fixed 16-bit PC to ADDR_W bits split into byte-wide halves.
- Loads low/high halves independently from the address buses, increments, and commits new values on phase-2.
- Adds relative-branch execution with 6502-accurate page-cross fix-up, an extra phase, and a vector load for reset/IRQ/NMI.
- Drives the PC onto ADL/ADH/DB through explicit output-enable pairs; the bus wrapper resolves them.

Parameters:
- BYTE_W, 8, width of each PC half and of each bus.
- ADDR_W, 16, total PC width; must equal 2*BYTE_W.
- RESET_ADDR, 16'h0000, value of PC after reset.

Ports:
- sys_clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- phase_2_rising  in  1  one-cycle pulse at phase-2 rising edge; the only commit point
- pcl_pcl, adl_pcl  in  1  level strobes selecting the next low half: hold PCL, or load from address_l_in
- pch_pch, adh_pch  in  1  level strobes selecting the next high half: hold PCH, or load from address_h_in
- increment_pc  in  1  add 1 at commit, sampled at phase_2_rising
- branch_take  in  1  level strobe starting a relative branch
- branch_offset  in  BYTE_W  signed two's-complement offset, captured on the branch_take edge
- vec_load  in  1  level strobe: load vec_addr at next commit
- vec_addr  in  ADDR_W  vector target
- address_l_in, address_h_in  in  BYTE_W  address bus values
- pcl_adl, pch_adh, pcl_db, pch_db  in  1  bus drive requests
- adl_out, adh_out, db_out  out  BYTE_W  drive data
- adl_oe, adh_oe, db_oe  out  1  drive enables
- pc  out  ADDR_W  current PC
- branch_busy  out  1  high while a page-cross fix-up is pending
- page_cross  out  1  one-cycle pulse on the fix-up commit

Behaviour:
- Reset:
  - pc = RESET_ADDR; select register = RESET_ADDR.
  - Edge-detect history = 0; state = IDLE.
  - branch_busy = 0, page_cross = 0; all oe = 0.
  - Reset wins over every other input and aborts any branch in progress.
- Edge detection:
  - Each strobe (pcl_pcl, adl_pcl, pch_pch, adh_pch, branch_take, vec_load) is registered.
  - rise = in & ~prev. A level held across multiple cycles acts exactly once.
- Select register (sel), updated on rises only:
  - High half: pch_pch rise -> pc[hi]; else adh_pch rise -> address_h_in; else hold.
  - Low half: pcl_pcl rise -> pc[lo]; else adl_pcl rise -> address_l_in; else hold.
- Pending flags:
  - vec_load rise sets vec_pend.
  - branch_take rise sets br_pend and captures branch_offset.
  - Both flags clear at the commit that consumes them.
- State machine: IDLE, FIX. Commit occurs only on phase_2_rising cycles.
- IDLE commit, priority high to low:
  - vec_pend: pc <= vec_addr; increment_pc is ignored.
  - br_pend:
    - lo_sum = {0,pc[lo]} + {0,offset}. new pc[lo] = lo_sum[BYTE_W-1:0].
    - Positive offset with carry, or negative offset without carry, is a page cross: go to FIX, branch_busy = 1, latch dir (+1 / -1), pc[hi] unchanged.
    - Otherwise stay in IDLE.
    - increment_pc is ignored.
  - else: pc <= sel + increment_pc, a full ADDR_W add wrapping all-ones -> 0.
- FIX commit:
  - pc[hi] <= pc[hi] + dir, wrapping modulo 2^BYTE_W.
  - page_cross = 1 for that cycle; return to IDLE; branch_busy = 0.
  - Strobe rises during FIX still update sel and pending flags; they are consumed at the following IDLE commit.
- sel tracking: after any commit, sel <= new pc unless a strobe rise in the same cycle overrides that half (the rise wins).
- Bus outputs, combinational from pc:
  - adl_out = pc[lo], adl_oe = pcl_adl; adh_out = pc[hi], adh_oe = pch_adh.
  - db: pch_db -> pc[hi]; else pcl_db -> pc[lo]; db_oe = pcl_db | pch_db. pch_db has priority when both are set.

Decomposition:
- Shared package cpu_pkg: BYTE_W, ADDR_W, RESET_ADDR, and a state enum {IDLE, FIX}.
- Sub-module edge_rise (parametrised width N, registered rising-edge detector), instantiated once with N=6.

Test Plan:
- Reset, then 3 commits with increment_pc=1 and pcl_pcl/pch_pch pulsed before each -> pc 0000, 0001, 0002, 0003.
- address_l_in=34, address_h_in=12; pulse adl_pcl and adh_pch; commit with inc=0 -> pc=1234, adl_out=34 when pcl_adl=1, db_out=12 when pch_db=pcl_db=1.
- pc=10F0, branch_take with offset=+0x20 -> commit1 pc=1010, branch_busy=1; commit2 pc=1110, page_cross pulse.
- pc=1005, offset=0xF0 (-16) -> pc=10F5 then 0FF5; offset=0x02 from 1005 -> 1007, no FIX.
- pc=FFFF, increment commit -> 0000. vec_load with vec_addr=FFFC and increment_pc=1 on the same commit -> FFFC.
- Assert reset while in FIX -> pc=RESET_ADDR, branch_busy=0, no page_cross pulse. Hold adl_pcl high for 5 cycles -> sel loads once only.
